// File: rtl/sd_block_buffer_if.sv
// Controller-side bundle between sd_block_buffer and sd_card_controller.
// master = buffer/sequencer, slave = card controller.
interface sd_block_buffer_if;
  logic        ctl_op_code;
  logic        ctl_execute;
  logic [31:0] ctl_block_address;
  logic [7:0]  ctl_outgoing_byte;
  logic [7:0]  ctl_incoming_byte;
  logic        ctl_finished_byte;
  logic        ctl_finished_block;
  logic        ctl_busy;

  modport master (
    output ctl_op_code,
    output ctl_execute,
    output ctl_block_address,
    output ctl_outgoing_byte,
    input  ctl_incoming_byte,
    input  ctl_finished_byte,
    input  ctl_finished_block,
    input  ctl_busy
  );

  modport slave (
    input  ctl_op_code,
    input  ctl_execute,
    input  ctl_block_address,
    input  ctl_outgoing_byte,
    output ctl_incoming_byte,
    output ctl_finished_byte,
    output ctl_finished_block,
    output ctl_busy
  );
endinterface

// File: rtl/sd_block_buffer.sv
// 512-byte block buffer and transfer sequencer for sd_card_controller.
// Optional CRC-16-CCITT over transferred bytes: define SD_BUF_CRC16_EN.
module sd_block_buffer #(
  parameter int BLOCK_BYTES   = 512,
  parameter int IDX_W         = 9,
  parameter int START_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             btn_n,
  input  logic             host_start,
  input  logic             host_op,
  input  logic [31:0]      host_block_addr,
  input  logic [IDX_W-1:0] buf_addr,
  input  logic             buf_wr,
  input  logic [7:0]       buf_wdata,
  output logic [7:0]       buf_rdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      crc_out,
  sd_block_buffer_if.master ctl
);

  localparam int TMO_W =
    (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [IDX_W:0] BB_W =
    (IDX_W+1)'(BLOCK_BYTES);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_XFER
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W:0]   idx_q, idx_d;
  logic             op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             ovf_q, ovf_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       rdata_q, rdata_d;

  logic [7:0]       mem [BLOCK_BYTES];
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [7:0]       mem_wdata;
  logic             buf_ok;
  logic             byte_ok;
  logic [7:0]       out_byte;

  assign buf_ok  = ({1'b0, buf_addr} < BB_W);
  assign byte_ok = (state_q == S_XFER) &&
                   ctl.ctl_finished_byte &&
                   (idx_q < BB_W);
  assign out_byte = (state_q == S_IDLE) ? 8'h00 :
                    mem[idx_q[IDX_W-1:0]];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q[IDX_W-1:0];
    mem_wdata = ctl.ctl_incoming_byte;
    unique case (state_q)
      S_IDLE: begin
        if (buf_wr && buf_ok) begin
          mem_we    = 1'b1;
          mem_waddr = buf_addr;
          mem_wdata = buf_wdata;
        end
        if (host_start) begin
          if (ctl.ctl_busy) begin
            error_d = 1'b1;
          end else begin
            op_d    = host_op;
            addr_d  = host_block_addr;
            busy_d  = 1'b1;
            idx_d   = '0;
            ovf_d   = 1'b0;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ctl.ctl_busy) begin
          state_d = S_XFER;
        end else if (tmo_q == TMO_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_XFER: begin
        if (byte_ok) begin
          idx_d  = idx_q + 1'b1;
          mem_we = !op_q;
        end
        if (ctl.ctl_finished_byte && !byte_ok) begin
          ovf_d = 1'b1;
        end
        // Same-cycle byte is already folded into idx_d/ovf_d.
        if (ctl.ctl_finished_block) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (idx_d == BB_W && !ovf_d) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = buf_ok ? mem[buf_addr] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge btn_n) begin
    if (!btn_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef SD_BUF_CRC16_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) :
                  {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (state_q == S_LAUNCH) begin
      crc_d = 16'h0000;
    end else if (byte_ok) begin
      crc_d = crc16_byte(crc_q,
        op_q ? out_byte : ctl.ctl_incoming_byte);
    end
  end

  always_ff @(posedge clk or negedge btn_n) begin
    if (!btn_n) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;
`else
  assign crc_out = 16'h0000;
`endif

  assign buf_rdata             = rdata_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign error                 = error_q;
  assign ctl.ctl_op_code       = op_q;
  assign ctl.ctl_execute       = (state_q == S_LAUNCH);
  assign ctl.ctl_block_address = addr_q;
  assign ctl.ctl_outgoing_byte = out_byte;

endmodule

// File: tb/tb_sd_block_buffer.sv
// Self-checking bench for sd_block_buffer: vector table, scoreboard
// queue and hand-written multi-cycle sequences.
module tb_sd_block_buffer;

  localparam int TMO = 1024;

  logic        clk;
  logic        btn_n;
  logic        host_start;
  logic        host_op;
  logic [31:0] host_block_addr;
  logic [8:0]  buf_addr;
  logic        buf_wr;
  logic [7:0]  buf_wdata;
  logic [7:0]  buf_rdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] crc_out;

  sd_block_buffer_if cif();

  sd_block_buffer dut (
    .clk             (clk),
    .btn_n           (btn_n),
    .host_start      (host_start),
    .host_op         (host_op),
    .host_block_addr (host_block_addr),
    .buf_addr        (buf_addr),
    .buf_wr          (buf_wr),
    .buf_wdata       (buf_wdata),
    .buf_rdata       (buf_rdata),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .crc_out         (crc_out),
    .ctl             (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vec_cnt;
  int         miss_cnt;
  logic [7:0] model_mem [512];
  logic [7:0] sb [$];

  typedef struct {
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [8:0] a,
                            input logic [7:0] d);
    buf_addr  = a;
    buf_wdata = d;
    buf_wr    = 1'b1;
    model_mem[a] = d;
    tick;
    buf_wr = 1'b0;
  endtask

  task automatic host_read(input string name,
                           input logic [8:0] a);
    logic [7:0] e;
    buf_addr = a;
    sb.push_back(model_mem[a]);
    tick;
    e = sb.pop_front();
    chk(name, buf_rdata, e);
  endtask

  task automatic run_xfer(input logic op,
                          input logic [31:0] baddr,
                          input int n,
                          input bit merge,
                          input bit poke,
                          input bit exp_done,
                          input string tag);
    logic [7:0] e;
    logic [7:0] b;
    if (op) begin
      for (int i = 0; i < n && i < 512; i++)
        sb.push_back(model_mem[i]);
    end
    host_op         = op;
    host_block_addr = baddr;
    host_start      = 1'b1;
    tick;
    host_start = 1'b0;
    chk({tag, "_exec"}, cif.ctl_execute, 1);
    chk({tag, "_busy"}, busy, 1);
    if (op)
      chk({tag, "_out0"}, cif.ctl_outgoing_byte,
          model_mem[0]);
    if (poke) begin
      buf_addr  = 9'd5;
      buf_wdata = 8'hAA;
      buf_wr    = 1'b1;
    end
    tick;
    buf_wr = 1'b0;
    chk({tag, "_exec1"}, cif.ctl_execute, 0);
    cif.ctl_busy = 1'b1;
    tick;
    chk({tag, "_baddr"}, cif.ctl_block_address, baddr);
    chk({tag, "_opc"}, cif.ctl_op_code, op);
    for (int i = 0; i < n; i++) begin
      b = i[7:0];
      if (op && i < 512) begin
        e = sb.pop_front();
        vec_cnt++;
        if (cif.ctl_outgoing_byte !== e) begin
          miss_cnt++;
          $display("FAIL %s_out[%0d]: got %h expected %h",
                   tag, i, cif.ctl_outgoing_byte, e);
        end
      end
      cif.ctl_incoming_byte = ~b;
      if (!op && i < 512) model_mem[i] = ~b;
      cif.ctl_finished_byte = 1'b1;
      if (merge && i == n - 1)
        cif.ctl_finished_block = 1'b1;
      tick;
    end
    cif.ctl_finished_byte = 1'b0;
    if (!merge) begin
      cif.ctl_finished_block = 1'b1;
      tick;
    end
    cif.ctl_finished_block = 1'b0;
    cif.ctl_busy = 1'b0;
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, error, !exp_done);
    chk({tag, "_busy_end"}, busy, 0);
    tick;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_err_pulse"}, error, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vec_cnt    = 0;
    miss_cnt   = 0;
    btn_n      = 1'b0;
    host_start = 1'b0;
    host_op    = 1'b0;
    host_block_addr = '0;
    buf_addr   = '0;
    buf_wr     = 1'b0;
    buf_wdata  = '0;
    cif.ctl_incoming_byte  = '0;
    cif.ctl_finished_byte  = 1'b0;
    cif.ctl_finished_block = 1'b0;
    cif.ctl_busy           = 1'b0;
    for (int i = 0; i < 512; i++) model_mem[i] = 8'h00;

    tbl[0] = '{9'd0,   8'h11, 8'h11};
    tbl[1] = '{9'd1,   8'h22, 8'h22};
    tbl[2] = '{9'd5,   8'h5A, 8'h5A};
    tbl[3] = '{9'd255, 8'hFF, 8'hFF};
    tbl[4] = '{9'd256, 8'h80, 8'h80};
    tbl[5] = '{9'd510, 8'h7E, 8'h7E};
    tbl[6] = '{9'd511, 8'hC3, 8'hC3};
    tbl[7] = '{9'd100, 8'h00, 8'h00};

    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_crc", crc_out, 0);
    chk("rst_exec", cif.ctl_execute, 0);
    chk("rst_opc", cif.ctl_op_code, 0);
    chk("rst_baddr", cif.ctl_block_address, 0);
    chk("rst_out", cif.ctl_outgoing_byte, 0);
    chk("rst_rdata", buf_rdata, 0);
    btn_n = 1'b1;
    tick;

    for (int i = 0; i < 8; i++)
      host_write(tbl[i].addr, tbl[i].wdata);
    for (int i = 0; i < 8; i++) begin
      buf_addr = tbl[i].addr;
      sb.push_back(tbl[i].exp);
      tick;
      cnt = 0;
      chk($sformatf("tbl_rd[%0d]", i), buf_rdata,
          sb.pop_front());
    end

    for (int i = 0; i < 512; i++)
      host_write(i[8:0], i[7:0]);
    run_xfer(1'b1, 32'h0000_0010, 512, 0, 1, 1, "wr");
    buf_addr = 9'd5;
    tick;
    chk("wr_poke_mem5", buf_rdata, 8'h05);
`ifndef SD_BUF_CRC16_EN
    chk("crc_tied0", crc_out, 16'h0000);
`endif

    run_xfer(1'b0, 32'h0000_0020, 512, 0, 0, 1, "rd");
    buf_addr = 9'd3;
    tick;
    chk("rd_addr3", buf_rdata, 8'hFC);
    host_read("rd_addr511", 9'd511);
    host_read("rd_addr0", 9'd0);

    run_xfer(1'b1, 32'h0000_0030, 100, 0, 0, 0, "short");
    run_xfer(1'b1, 32'h0000_0031, 512, 1, 0, 1, "merge");
    run_xfer(1'b1, 32'h0000_0032, 513, 0, 0, 0, "ovf");

    cif.ctl_busy = 1'b1;
    host_op    = 1'b1;
    host_start = 1'b1;
    tick;
    host_start = 1'b0;
    chk("bsy_start_err", error, 1);
    chk("bsy_start_busy", busy, 0);
    chk("bsy_start_exec", cif.ctl_execute, 0);
    cif.ctl_busy = 1'b0;
    tick;
    chk("bsy_start_exec2", cif.ctl_execute, 0);
    chk("bsy_start_err2", error, 0);

    host_op = 1'b1;
    host_block_addr = 32'h0000_0044;
    host_start = 1'b1;
    tick;
    host_start = 1'b0;
    cnt = 1;
    while (!error && cnt < 2000) begin
      tick;
      cnt++;
    end
    chk("tmo_cycles", cnt, TMO + 2);
    chk("tmo_busy", busy, 0);
    chk("tmo_done", done, 0);

    host_op = 1'b1;
    host_block_addr = 32'h0000_0040;
    host_start = 1'b1;
    tick;
    host_start = 1'b0;
    tick;
    cif.ctl_busy = 1'b1;
    tick;
    cif.ctl_finished_byte = 1'b1;
    repeat (10) tick;
    cif.ctl_finished_byte = 1'b0;
    cif.ctl_busy = 1'b0;
    btn_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_exec", cif.ctl_execute, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", error, 0);
    chk("midrst_out", cif.ctl_outgoing_byte, 0);
    tick;
    btn_n = 1'b1;
    tick;
    chk("midrst_done2", done, 0);
    chk("midrst_err2", error, 0);
    run_xfer(1'b0, 32'h0000_0050, 512, 0, 0, 1, "rec");
    host_read("rec_addr7", 9'd7);

`ifdef SD_BUF_CRC16_EN
    for (int i = 0; i < 512; i++)
      host_write(i[8:0], 8'h00);
    run_xfer(1'b1, 32'h0000_0060, 512, 0, 0, 1, "crc0");
    chk("crc_zero", crc_out, 16'h0000);
    host_write(9'd511, 8'h01);
    run_xfer(1'b1, 32'h0000_0061, 512, 0, 0, 1, "crc1");
    chk("crc_one", crc_out, 16'h1021);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, miss_cnt);
    $finish;
  end

endmodule
